// File: rtl/alu_host_pkg.sv
// Shared definitions for the multi-cycle ALU and its host sequencer:
// sequencer state encoding, opcode constants and a state classification helper.
package alu_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_OPA   = 3'd2,
      ST_OPB   = 3'd3,
      ST_WAIT  = 3'd4,
      ST_RESP  = 3'd5
   } state_t;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t OP_ADD = 4'd0;
   localparam alu_op_t OP_SUB = 4'd1;
   localparam alu_op_t OP_MUL = 4'd2;
   localparam alu_op_t OP_DIV = 4'd3;
   localparam alu_op_t OP_AND = 4'd4;
   localparam alu_op_t OP_OR  = 4'd5;
   localparam alu_op_t OP_XOR = 4'd6;
   localparam alu_op_t OP_NOT = 4'd7;

   // True while an operation is in flight on the ALU (START through WAIT).
   function automatic logic is_busy(input state_t s);
      return (s == ST_START) || (s == ST_OPA) || (s == ST_OPB) || (s == ST_WAIT);
   endfunction

endpackage

// File: rtl/alu_host_if.sv
// Request, response and ALU-side signals of the alu_host sequencer, bundled as one interface.
interface alu_host_if #(
   parameter int W = 16
);
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_op;
   logic [W-1:0]  req_a;
   logic [W-1:0]  req_b;

   logic          alu_start;
   logic [3:0]    alu_s;
   logic [W-1:0]  alu_inbus;
   logic [W-1:0]  alu_outbus;
   logic          alu_negative;
   logic          alu_zero;
   logic          alu_carry;
   logic          alu_overflow;
   logic          alu_finish;

   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_hi;
   logic [W-1:0]  rsp_lo;
   logic [3:0]    rsp_flags;
   logic          rsp_err;

   // slave is the sequencer; master is everything around it (requester, ALU, response sink).
   modport slave (
      input  req_valid, req_op, req_a, req_b,
      input  alu_outbus, alu_negative, alu_zero, alu_carry, alu_overflow, alu_finish,
      input  rsp_ready,
      output req_ready, alu_start, alu_s, alu_inbus,
      output rsp_valid, rsp_hi, rsp_lo, rsp_flags, rsp_err
   );

   modport master (
      output req_valid, req_op, req_a, req_b,
      output alu_outbus, alu_negative, alu_zero, alu_carry, alu_overflow, alu_finish,
      output rsp_ready,
      input  req_ready, alu_start, alu_s, alu_inbus,
      input  rsp_valid, rsp_hi, rsp_lo, rsp_flags, rsp_err
   );

endinterface

// File: rtl/alu_host_timer.sv
// Clearable up-counter with terminal-count flag; saturates at TIMEOUT-1 so it never wraps.
module alu_host_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic                        clk,
   input  logic                        rst_b,
   input  logic                        clr_i,
   input  logic                        en_i,
   output logic [$clog2(TIMEOUT)-1:0]  count_o,
   output logic                        tc_o
);
   localparam int               CNT_W  = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             tc;

   assign tc = (count_q == TC_VAL);

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && !tc) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign tc_o    = tc;

endmodule

// File: rtl/alu_host.sv
// alu_host: accepts an ALU request, sequences start/operands onto the ALU bus, captures the
// two result words preceding finish plus flags, and returns them with a timeout abort guard.
module alu_host
   import alu_host_pkg::*;
#(
   parameter int W       = 16,
   parameter int OPA_CYC = 1,
   parameter int TIMEOUT = 64
) (
   input  logic      clk,
   input  logic      rst_b,
   alu_host_if.slave bus
);
   localparam int CNT_W = $clog2(TIMEOUT);

   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     hold_hi_q, hold_hi_d;
   logic [W-1:0]     hold_lo_q, hold_lo_d;
   logic [W-1:0]     rsp_hi_q, rsp_hi_d;
   logic [W-1:0]     rsp_lo_q, rsp_lo_d;
   logic [3:0]       rsp_flags_q, rsp_flags_d;
   logic             rsp_err_q, rsp_err_d;

   logic             busy;
   logic             tmr_clr;
   logic             tmr_en;
   logic             tmr_tc;
   logic [CNT_W-1:0] tmr_count;

   logic             req_ready;
   logic             alu_start;
   logic [3:0]       alu_s;
   logic [W-1:0]     alu_inbus;
   logic             rsp_valid;

   alu_host_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst_b   (rst_b),
      .clr_i   (tmr_clr),
      .en_i    (tmr_en),
      .count_o (tmr_count),
      .tc_o    (tmr_tc)
   );

   assign busy = is_busy(state_q);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      hold_hi_d   = hold_hi_q;
      hold_lo_d   = hold_lo_q;
      rsp_hi_d    = rsp_hi_q;
      rsp_lo_d    = rsp_lo_q;
      rsp_flags_d = rsp_flags_q;
      rsp_err_d   = rsp_err_q;
      req_ready   = 1'b0;
      alu_start   = 1'b0;
      alu_s       = 4'd0;
      alu_inbus   = '0;
      rsp_valid   = 1'b0;
      tmr_clr     = 1'b0;
      tmr_en      = 1'b0;

      // The ALU presents hi then lo on the two cycles before finish; keep a two-deep history.
      if (busy) begin
         hold_hi_d = hold_lo_q;
         hold_lo_d = bus.alu_outbus;
         alu_s     = op_q;
         tmr_en    = !bus.alu_finish;
      end

      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            tmr_clr   = 1'b1;
            if (bus.req_valid) begin
               op_d    = bus.req_op;
               a_d     = bus.req_a;
               b_d     = bus.req_b;
               state_d = ST_START;
            end
         end
         ST_START: begin
            alu_start = 1'b1;
            alu_inbus = a_q;
            state_d   = ST_OPA;
         end
         ST_OPA: begin
            alu_inbus = a_q;
            if (int'(tmr_count) >= OPA_CYC) begin
               state_d = ST_OPB;
            end
         end
         ST_OPB: begin
            alu_inbus = b_q;
            state_d   = ST_WAIT;
         end
         ST_WAIT: begin
            alu_inbus = b_q;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            tmr_clr   = 1'b1;
            if (bus.rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Finish takes priority over a timeout landing in the same cycle.
      if (busy) begin
         if (bus.alu_finish) begin
            rsp_hi_d    = hold_hi_q;
            rsp_lo_d    = hold_lo_q;
            rsp_flags_d = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
            rsp_err_d   = 1'b0;
            state_d     = ST_RESP;
         end else if (tmr_tc) begin
            rsp_hi_d    = '0;
            rsp_lo_d    = '0;
            rsp_flags_d = 4'd0;
            rsp_err_d   = 1'b1;
            state_d     = ST_RESP;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q     <= ST_IDLE;
         op_q        <= 4'd0;
         a_q         <= '0;
         b_q         <= '0;
         hold_hi_q   <= '0;
         hold_lo_q   <= '0;
         rsp_hi_q    <= '0;
         rsp_lo_q    <= '0;
         rsp_flags_q <= 4'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         hold_hi_q   <= hold_hi_d;
         hold_lo_q   <= hold_lo_d;
         rsp_hi_q    <= rsp_hi_d;
         rsp_lo_q    <= rsp_lo_d;
         rsp_flags_q <= rsp_flags_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.alu_start = alu_start;
   assign bus.alu_s     = alu_s;
   assign bus.alu_inbus = alu_inbus;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_hi    = rsp_hi_q;
   assign bus.rsp_lo    = rsp_lo_q;
   assign bus.rsp_flags = rsp_flags_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_host.sv
// Self-checking bench for alu_host: behavioural ALU model plus directed and randomized transactions.
module tb_alu_host;
   import alu_host_pkg::*;

   localparam int W       = 16;
   localparam int OPA_CYC = 1;
   localparam int TIMEOUT = 64;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic [3:0]   flags;
   } res_t;

   logic clk   = 1'b0;
   logic rst_b = 1'b0;

   alu_host_if #(.W(W)) bus ();

   alu_host #(
      .W       (W),
      .OPA_CYC (OPA_CYC),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int lat_cfg   = 6;
   int spur_cyc  = -1;
   int start_cnt = 0;
   int fin_cyc   = 0;
   int txn_no    = 0;

   logic [W-1:0] last_hi, last_lo;
   logic [3:0]   last_flags;
   logic         last_err;

   always @(posedge clk) cyc <= cyc + 1;

   // Arithmetic meaning of each opcode; flags are {negative, zero, carry, overflow}.
   function automatic res_t alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t             r;
      logic [W:0]       s;
      logic [2*W-1:0]   p;
      logic             c, v;
      r = '0; s = '0; p = '0; c = 1'b0; v = 1'b0;
      case (op)
         OP_ADD: begin
            s    = {1'b0, a} + {1'b0, b};
            r.lo = s[W-1:0];
            c    = s[W];
            v    = (a[W-1] == b[W-1]) && (r.lo[W-1] != a[W-1]);
         end
         OP_SUB: begin
            r.lo = a - b;
            c    = (a < b);
            v    = (a[W-1] != b[W-1]) && (r.lo[W-1] != a[W-1]);
         end
         OP_MUL: begin
            p    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            r.hi = p[2*W-1:W];
            r.lo = p[W-1:0];
            c    = (r.hi != '0);
         end
         OP_DIV: begin
            if (b == '0) begin
               r.hi = a;
               r.lo = '1;
               v    = 1'b1;
            end else begin
               r.hi = a % b;
               r.lo = a / b;
            end
         end
         OP_AND:  r.lo = a & b;
         OP_OR:   r.lo = a | b;
         OP_XOR:  r.lo = a ^ b;
         OP_NOT:  r.lo = ~a;
         default: r.lo = '0;
      endcase
      r.flags = {((op == OP_MUL) ? r.hi[W-1] : r.lo[W-1]), ({r.hi, r.lo} == '0), c, v};
      return r;
   endfunction

   // Behavioural ALU: samples a at start and b on the OPB cycle, shows hi/lo the two cycles
   // before finish and noise everywhere else. lat_cfg==0 models a hung ALU.
   logic         m_busy = 1'b0;
   int           m_k    = 0;
   int           m_lat  = 0;
   logic [3:0]   m_op   = 4'd0;
   logic [W-1:0] m_a    = '0;
   logic [W-1:0] m_b    = '0;
   res_t         mr;

   always_comb mr = alu_ref(m_op, m_a, m_b);

   always @(negedge clk) begin
      if (!rst_b) begin
         m_busy         <= 1'b0;
         m_k            <= 0;
         bus.alu_outbus <= '0;
         bus.alu_finish <= 1'b0;
         {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow} <= 4'd0;
      end else begin
         bus.alu_outbus <= W'($urandom);
         {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow} <= 4'($urandom);
         bus.alu_finish <= 1'b0;
         if (bus.alu_start === 1'b1) begin
            m_busy    <= 1'b1;
            m_k       <= 1;
            m_op      <= bus.alu_s;
            m_a       <= bus.alu_inbus;
            m_lat     <= lat_cfg;
            start_cnt <= start_cnt + 1;
         end else if (m_busy) begin
            m_k <= m_k + 1;
            if (m_k == OPA_CYC + 1) m_b <= bus.alu_inbus;
            if (m_lat > 0) begin
               if (m_k == m_lat - 2) bus.alu_outbus <= mr.hi;
               if (m_k == m_lat - 1) bus.alu_outbus <= mr.lo;
               if (m_k == m_lat) begin
                  bus.alu_finish <= 1'b1;
                  {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow} <= mr.flags;
                  m_busy  <= 1'b0;
                  fin_cyc <= cyc;
               end
            end
         end else if (cyc == spur_cyc) begin
            bus.alu_finish <= 1'b1;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_rsp(input int bound);
      int n;
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < bound) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_valid_within_bound", bus.rsp_valid, 1'b1);
   endtask

   // One full request/response transaction with operand-bus, latency and hold checks.
   task automatic run_txn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int lat, input int rdy_dly);
      res_t         exp_r;
      int           t0, n, bus_bad, stab_bad, s0, exp_cyc;
      logic [W-1:0] exp_bus, snap_hi, snap_lo;
      logic [3:0]   snap_fl;
      logic         snap_err;
      exp_r   = (lat == 0) ? res_t'('0) : alu_ref(op, a, b);
      lat_cfg = lat;
      @(negedge clk);
      chk("idle_req_ready", bus.req_ready, 1'b1);
      s0 = start_cnt;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("start_pulse", bus.alu_start, 1'b1);
      chk("start_op", bus.alu_s, op);
      t0 = cyc; n = 0; bus_bad = 0;
      while (bus.rsp_valid !== 1'b1 && n < TIMEOUT + 8) begin
         exp_bus = (cyc - t0 <= OPA_CYC) ? a : b;
         if (bus.alu_inbus !== exp_bus || bus.alu_s !== op || bus.req_ready !== 1'b0 ||
             (cyc != t0 && bus.alu_start !== 1'b0)) bus_bad++;
         @(negedge clk);
         n++;
      end
      chk("rsp_valid_seen", bus.rsp_valid, 1'b1);
      chk("alu_bus_sequence", bus_bad, 0);
      exp_cyc = (lat == 0) ? t0 + TIMEOUT : t0 + lat + 1;
      chk("rsp_latency", cyc, exp_cyc);
      if (lat > 0) chk("finish_to_valid", cyc - fin_cyc, 1);
      snap_hi = bus.rsp_hi; snap_lo = bus.rsp_lo; snap_fl = bus.rsp_flags; snap_err = bus.rsp_err;
      stab_bad = 0;
      for (int i = 0; i <= rdy_dly; i++) begin
         if (i == rdy_dly) bus.rsp_ready = 1'b1;
         if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.alu_start !== 1'b0 ||
             bus.alu_inbus !== '0 || bus.alu_s !== 4'd0 || bus.rsp_hi !== snap_hi ||
             bus.rsp_lo !== snap_lo || bus.rsp_flags !== snap_fl || bus.rsp_err !== snap_err) stab_bad++;
         @(negedge clk);
      end
      bus.rsp_ready = 1'b0;
      chk("rsp_hold", stab_bad, 0);
      chk("req_ready_after_rsp", bus.req_ready, 1'b1);
      chk("rsp_valid_drop", bus.rsp_valid, 1'b0);
      chk("rsp_hi", snap_hi, exp_r.hi);
      chk("rsp_lo", snap_lo, exp_r.lo);
      chk("rsp_flags", snap_fl, exp_r.flags);
      chk("rsp_err", snap_err, (lat == 0));
      chk("one_start_pulse", start_cnt - s0, 1);
      last_hi = snap_hi; last_lo = snap_lo; last_flags = snap_fl; last_err = snap_err;
      txn_no++;
      $display("txn %0d op=%0d a=%h b=%h lat=%0d -> hi=%h lo=%h flags=%b err=%b",
               txn_no, op, a, b, lat, snap_hi, snap_lo, snap_fl, snap_err);
   endtask

   initial begin
      int           h, t1;
      res_t         r1, r2;
      logic [3:0]   rop;
      logic [W-1:0] ra, rb;

      bus.req_valid = 1'b0;
      bus.req_op    = 4'd0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);

      chk("reset_req_ready", bus.req_ready, 1'b1);
      chk("reset_alu_start", bus.alu_start, 1'b0);
      chk("reset_alu_s", bus.alu_s, 4'd0);
      chk("reset_alu_inbus", bus.alu_inbus, '0);
      chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
      chk("reset_rsp_words", {bus.rsp_hi, bus.rsp_lo}, '0);
      chk("reset_rsp_flags", bus.rsp_flags, 4'd0);
      chk("reset_rsp_err", bus.rsp_err, 1'b0);
      rst_b = 1'b1;

      // ADD
      run_txn(OP_ADD, 16'h1234, 16'h0001, 6, 0);
      chk("add_lo_const", last_lo, 16'h1235);
      chk("add_hi_const", last_hi, 16'h0000);
      chk("add_flags_const", last_flags, 4'b0000);

      // MUL with a slow ALU
      run_txn(OP_MUL, 16'h0003, 16'h0004, 20, 0);
      chk("mul_lo_const", last_lo, 16'h000C);
      chk("mul_hi_const", last_hi, 16'h0000);

      // Hung ALU
      run_txn(OP_DIV, 16'h0100, 16'h0010, 0, 1);
      chk("timeout_err_const", last_err, 1'b1);

      // Backpressure for 10 cycles
      run_txn(OP_XOR, 16'hA5A5, 16'h0FF0, 9, 10);

      // Spurious finish while idle
      @(negedge clk);
      spur_cyc = cyc + 1;
      @(negedge clk);
      @(negedge clk);
      chk("spur_idle_rsp_valid", bus.rsp_valid, 1'b0);
      chk("spur_idle_req_ready", bus.req_ready, 1'b1);
      spur_cyc = -1;

      // Reset in the middle of WAIT
      lat_cfg = 50;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_op = OP_AND; bus.req_a = 16'h1111; bus.req_b = 16'h2222;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("wait_inbus_b", bus.alu_inbus, 16'h2222);
      rst_b = 1'b0;
      #1;
      chk("midreset_alu_start", bus.alu_start, 1'b0);
      chk("midreset_alu_inbus", bus.alu_inbus, '0);
      chk("midreset_req_ready", bus.req_ready, 1'b1);
      chk("midreset_alu_s", bus.alu_s, 4'd0);
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      run_txn(OP_SUB, 16'h0005, 16'h0007, 8, 0);
      chk("sub_lo_const", last_lo, 16'hFFFE);
      chk("sub_negative", last_flags[3], 1'b1);

      // Back-to-back with req_valid held and rsp_ready held
      r1 = alu_ref(OP_ADD, 16'h7FFF, 16'h0001);
      r2 = alu_ref(OP_XOR, 16'hF00F, 16'h0FF0);
      lat_cfg = 7;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_op = OP_ADD; bus.req_a = 16'h7FFF; bus.req_b = 16'h0001;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("b2b_first_start", bus.alu_start, 1'b1);
      bus.req_op = OP_XOR; bus.req_a = 16'hF00F; bus.req_b = 16'h0FF0;
      wait_rsp(TIMEOUT + 8);
      h = cyc;
      chk("b2b_first_lo", bus.rsp_lo, r1.lo);
      chk("b2b_first_flags", bus.rsp_flags, r1.flags);
      chk("b2b_busy_req_ready", bus.req_ready, 1'b0);
      spur_cyc = h + 1;
      lat_cfg  = 9;
      @(negedge clk);
      chk("b2b_idle_req_ready", bus.req_ready, 1'b1);
      chk("b2b_idle_rsp_valid", bus.rsp_valid, 1'b0);
      @(negedge clk);
      chk("b2b_second_start", bus.alu_start, 1'b1);
      chk("b2b_start_gap", cyc - h, 2);
      bus.req_valid = 1'b0;
      t1 = cyc;
      wait_rsp(TIMEOUT + 8);
      chk("b2b_second_latency", cyc - t1, 10);
      chk("b2b_second_hi", bus.rsp_hi, r2.hi);
      chk("b2b_second_lo", bus.rsp_lo, r2.lo);
      chk("b2b_second_flags", bus.rsp_flags, r2.flags);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      spur_cyc = -1;
      chk("b2b_done_req_ready", bus.req_ready, 1'b1);
      $display("txn b2b op=ADD,XOR -> lo=%h,%h", r1.lo, r2.lo);

      // Randomized traffic
      for (int i = 0; i < 16; i++) begin
         rop = 4'($urandom_range(0, 7));
         ra  = W'($urandom);
         rb  = (i % 5 == 4) ? '0 : W'($urandom);
         run_txn(rop, ra, rb, $urandom_range(6, 40), $urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule
